// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite slave definitions: response codes and FSM encodings.
// Imported by the register slave top and its register bank.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4lite_reg_bank.sv
// NUM_REGS x DW register storage with one sync write port,
// a combinational read port (registered by the caller) and a flat export.
module axi4lite_reg_bank #(
    parameter int NUM_REGS = 12,
    parameter int DW       = 32,
    parameter int IDX_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [DW-1:0]          wr_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DW-1:0]          rd_data,
    output logic [NUM_REGS*DW-1:0] regs_out
);

    logic [DW-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Unimplemented indices read as zero.
    assign rd_data = (32'(rd_idx) < 32'(NUM_REGS)) ? mem[rd_idx] : '0;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[k*DW +: DW] = mem[k];
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register slave; independent write and read FSMs.
// Define AXI_SLV_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 12
) (
    input  logic                                   s_aclk,
    input  logic                                   s_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                             s_awprot,
    input  logic                                   s_awvalid,
    output logic                                   s_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_wdata,
    input  logic                                   s_wvalid,
    output logic                                   s_wready,
    output logic [1:0]                             s_bresp,
    output logic                                   s_bvalid,
    input  logic                                   s_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                             s_arprot,
    input  logic                                   s_arvalid,
    output logic                                   s_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                             s_rresp,
    output logic                                   s_rvalid,
    input  logic                                   s_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW    = C_S_AXI_DATA_WIDTH;

`ifdef AXI_SLV_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    wr_state_t        w_state, w_next;
    rd_state_t        r_state, r_next;
    logic             aw_held, w_held, aw_held_nx, w_held_nx;
    logic [IDX_W-1:0] aw_idx_q, wr_idx, rd_idx;
    logic [DW-1:0]    w_data_q, wr_data, rd_data, rdata_nx;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             commit, wr_ok, rd_ok, wr_en;
    logic             awready_nx, wready_nx, arready_nx;
    logic             bvalid_nx, rvalid_nx;
    logic [1:0]       bresp_nx, rresp_nx;
    logic             unused;

    assign unused = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    // A channel handshaking this cycle counts as held for the commit.
    assign wr_idx  = aw_held ? aw_idx_q : s_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held ? w_data_q : s_wdata;
    assign rd_idx  = s_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign commit  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_ok   = 32'(wr_idx) < 32'(NUM_REGS);
    assign rd_ok   = 32'(rd_idx) < 32'(NUM_REGS);
    assign wr_en   = commit & wr_ok;

    always_comb begin
        w_next     = w_state;
        aw_held_nx = aw_held;
        w_held_nx  = w_held;
        bvalid_nx  = s_bvalid;
        bresp_nx   = s_bresp;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs) aw_held_nx = 1'b1;
                if (w_hs) w_held_nx = 1'b1;
                if (commit) begin
                    w_next    = W_RESP;
                    bvalid_nx = 1'b1;
                    bresp_nx  = wr_ok ? RESP_OKAY : OOR_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_next     = W_IDLE;
                    aw_held_nx = 1'b0;
                    w_held_nx  = 1'b0;
                    bvalid_nx  = 1'b0;
                end
            end
            default: ;
        endcase
        // Readies are registered from the next state, so none follows a valid.
        awready_nx = (w_next == W_IDLE) & ~aw_held_nx;
        wready_nx  = (w_next == W_IDLE) & ~w_held_nx;
    end

    always_comb begin
        r_next    = r_state;
        rvalid_nx = s_rvalid;
        rdata_nx  = s_rdata;
        rresp_nx  = s_rresp;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_next    = R_DATA;
                    rvalid_nx = 1'b1;
                    rdata_nx  = rd_data;
                    rresp_nx  = rd_ok ? RESP_OKAY : OOR_RESP;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    r_next    = R_IDLE;
                    rvalid_nx = 1'b0;
                end
            end
            default: ;
        endcase
        arready_nx = (r_next == R_IDLE);
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else begin
            w_state   <= w_next;
            r_state   <= r_next;
            aw_held   <= aw_held_nx;
            w_held    <= w_held_nx;
            if (aw_hs) aw_idx_q <= s_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) w_data_q <= s_wdata;
            s_awready <= awready_nx;
            s_wready  <= wready_nx;
            s_bvalid  <= bvalid_nx;
            s_bresp   <= bresp_nx;
            s_arready <= arready_nx;
            s_rvalid  <= rvalid_nx;
            s_rdata   <= rdata_nx;
            s_rresp   <= rresp_nx;
        end
    end

    axi4lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DW       (DW),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk      (s_aclk),
        .rst      (s_areset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .regs_out (regs_out)
    );

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs: directed cases plus random traffic
// checked against an array model of the register map.
module tb_axi4lite_slave_regs;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 12;

`ifdef AXI_SLV_ERR_RESP_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic          s_aclk = 1'b0;
    logic          s_areset;
    logic [AW-1:0] s_awaddr;
    logic [2:0]    s_awprot;
    logic          s_awvalid;
    logic          s_awready;
    logic [DW-1:0] s_wdata;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic [2:0]    s_arprot;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [NR*DW-1:0] regs_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [NR];
    logic [1:0]  bq[$];
    rexp_t       rq[$];

    always #5 s_aclk = ~s_aclk;

    axi4lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .s_aclk    (s_aclk),
        .s_areset  (s_areset),
        .s_awaddr  (s_awaddr),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .regs_out  (regs_out)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
        return int'(a[AW-1:2]) < NR;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
        return in_range(a) ? 2'b00 : OOR;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        return in_range(a) ? model[int'(a[AW-1:2])] : 32'h0;
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    function automatic logic sig_of(input int sel);
        case (sel)
            0: return s_awready;
            1: return s_wready;
            2: return s_arready;
            3: return s_bvalid;
            default: return s_rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge s_aclk);
            if (sig_of(sel)) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting, got 0, expected 1", name);
    endtask

    task automatic write_txn(input logic [AW-1:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly, input int b_dly);
        bq.push_back(exp_resp(addr));
        if (in_range(addr)) model[int'(addr[AW-1:2])] = data;
        fork
            begin
                repeat (aw_dly) @(posedge s_aclk);
                #1;
                s_awaddr  = addr;
                s_awvalid = 1'b1;
                wait_sig(0, "aw_hs");
                @(posedge s_aclk);
                #1 s_awvalid = 1'b0;
                if (w_dly > aw_dly) begin
                    @(negedge s_aclk);
                    check("awready_held", 64'(s_awready), 64'(0));
                end
            end
            begin
                repeat (w_dly) @(posedge s_aclk);
                #1;
                s_wdata  = data;
                s_wvalid = 1'b1;
                wait_sig(1, "w_hs");
                @(posedge s_aclk);
                #1 s_wvalid = 1'b0;
                if (aw_dly > w_dly) begin
                    @(negedge s_aclk);
                    check("wready_held", 64'(s_wready), 64'(0));
                end
            end
        join
        @(negedge s_aclk);
        check("b_lat", 64'({s_bvalid, s_awready, s_wready}), 64'(3'b100));
        for (int i = 0; i < b_dly; i++) begin
            @(negedge s_aclk);
            check("b_hold", 64'({s_bvalid, s_awready}), 64'(2'b10));
        end
        @(posedge s_aclk);
        #1 s_bready = 1'b1;
        wait_sig(3, "b_hs");
        @(posedge s_aclk);
        #1 s_bready = 1'b0;
        tests++;
        if (regs_out !== model_flat()) begin
            fails++;
            $display("FAIL regs_out: got 0x%0h, expected 0x%0h", regs_out, model_flat());
        end
    endtask

    task automatic read_txn(input logic [AW-1:0] addr, input logic [31:0] ed,
                            input logic [1:0] er, input int r_dly);
        rq.push_back('{d: ed, r: er});
        s_araddr  = addr;
        s_arvalid = 1'b1;
        wait_sig(2, "ar_hs");
        @(posedge s_aclk);
        #1 s_arvalid = 1'b0;
        @(negedge s_aclk);
        check("r_lat", 64'({s_rvalid, s_arready}), 64'(2'b10));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge s_aclk);
            check("r_hold", {29'h0, s_rvalid, s_arready, s_rdata},
                  {29'h0, 1'b1, 1'b0, ed});
        end
        @(posedge s_aclk);
        #1 s_rready = 1'b1;
        wait_sig(4, "r_hs");
        @(posedge s_aclk);
        #1 s_rready = 1'b0;
    endtask

    always @(negedge s_aclk) begin
        logic [1:0] eb;
        rexp_t      er;
        if (!s_areset && s_bvalid && s_bready) begin
            if (bq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got bresp 0x%0h, expected none", s_bresp);
            end else begin
                eb = bq.pop_front();
                check("bresp", 64'(s_bresp), 64'(eb));
            end
        end
        if (!s_areset && s_rvalid && s_rready) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r_unexpected: got rdata 0x%0h, expected none", s_rdata);
            end else begin
                er = rq.pop_front();
                check("rdata", 64'(s_rdata), 64'(er.d));
                check("rresp", 64'(s_rresp), 64'(er.r));
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [31:0]   old;
        s_areset  = 1'b1;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        repeat (3) @(posedge s_aclk);
        @(negedge s_aclk);
        check("reset_outs", {25'h0, s_awready, s_wready, s_bvalid, s_bresp,
              s_arready, s_rvalid, s_rresp, s_rdata}, 64'h0);
        check("reset_regs", 64'(regs_out == '0), 64'(1));
        @(posedge s_aclk);
        #1 s_areset = 1'b0;

        read_txn(6'h00, 32'h0, 2'b00, 0);
        write_txn(6'h08, 32'hDEADBEEF, 0, 0, 0);
        check("reg2", 64'(regs_out[2*DW +: DW]), 64'(32'hDEADBEEF));
        read_txn(6'h08, 32'hDEADBEEF, 2'b00, 0);
        write_txn(6'h04, 32'h12345678, 3, 0, 0);
        check("reg1", 64'(regs_out[1*DW +: DW]), 64'(32'h12345678));
        write_txn(6'h14, 32'hCAFEF00D, 0, 2, 5);
        read_txn(6'h14, 32'hCAFEF00D, 2'b00, 5);
        write_txn(6'h3C, 32'hFFFFFFFF, 0, 0, 1);
        read_txn(6'h3C, 32'h0, OOR, 1);

        write_txn(6'h0C, 32'hA5A5A5A5, 0, 0, 0);
        old = model_read(6'h0C);
        fork
            write_txn(6'h0C, 32'h1, 0, 0, 0);
            read_txn(6'h0C, old, 2'b00, 0);
        join
        read_txn(6'h0C, 32'h1, 2'b00, 0);

        for (int i = 0; i < 80; i++) begin
            a = AW'($urandom_range(0, 63));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                write_txn(a, d, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            end else begin
                read_txn(a, model_read(a), exp_resp(a), $urandom_range(0, 3));
            end
        end

        @(posedge s_aclk);
        #1;
        s_awaddr  = 6'h10;
        s_wdata   = 32'h0BADF00D;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        @(negedge s_aclk);
        check("rst_rdy", 64'({s_awready, s_wready}), 64'(2'b11));
        @(posedge s_aclk);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        @(negedge s_aclk);
        check("rst_bv_pre", 64'(s_bvalid), 64'(1));
        @(posedge s_aclk);
        #1 s_areset = 1'b1;
        @(posedge s_aclk);
        #1 s_areset = 1'b0;
        @(negedge s_aclk);
        check("rst_bv", 64'(s_bvalid), 64'(0));
        check("rst_regs", 64'(regs_out == '0), 64'(1));
        for (int k = 0; k < NR; k++) model[k] = '0;
        @(posedge s_aclk);
        #1;
        read_txn(6'h08, 32'h0, 2'b00, 0);

        repeat (4) @(posedge s_aclk);
        check("bq_drained", 64'(bq.size()), 64'(0));
        check("rq_drained", 64'(rq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_slave_regs.md
# axi4lite_slave_regs

AXI4-Lite slave endpoint that answers the single-beat write and read transactions issued by the team's AXI4-Lite master. It is backed by a bank of NUM_REGS 32-bit registers. It sits on the slave side of the master-slave link and exports the whole register bank flat to surrounding logic. Write and read channels run independently, with at most one outstanding transaction per direction.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 12: number of implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2).
- s_aclk  in  1  the single clock; all logic on its rising edge.
- s_areset  in  1  reset, synchronous, active-high.
- s_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_awprot  in  3  ignored.
- s_awvalid / s_awready  in / out  1  write-address handshake.
- s_wdata  in  C_S_AXI_DATA_WIDTH  write data; all bytes written, there is no strobe.
- s_wvalid / s_wready  in / out  1  write-data handshake.
- s_bresp  out  2  write response.
- s_bvalid / s_bready  out / in  1  write-response handshake.
- s_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_arprot  in  3  ignored.
- s_arvalid / s_arready  in / out  1  read-address handshake.
- s_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_rresp  out  2  read response.
- s_rvalid / s_rready  out / in  1  read-data handshake.
- regs_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flat register bank; register k occupies bits [32k+31:32k].

## Operation
- Reset values: all registers 0; s_awready=0, s_wready=0, s_bvalid=0, s_bresp=0, s_arready=0, s_rvalid=0, s_rdata=0, s_rresp=0.
- Write FSM has states W_IDLE and W_RESP.
  - W_IDLE: s_awready = !aw_held; s_wready = !w_held.
  - An AW or W handshake latches that channel's address or data into its holding register and sets its held flag.
  - AW and W may arrive in either order or in the same cycle.
  - The write commits on the first edge at which both channels are held or handshaking; the FSM then moves to W_RESP.
- W_RESP: s_awready=0, s_wready=0, s_bvalid=1.
  - On s_bvalid & s_bready: clear both held flags and return to W_IDLE.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: s_arready=1. On the AR handshake, register s_rdata and s_rresp, then move to R_DATA.
  - R_DATA: s_arready=0, s_rvalid=1. s_rdata and s_rresp stay stable until s_rready; then return to R_IDLE.
- Address decode: index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored. An index ≥ NUM_REGS is out of range (handling is in Configuration).
- Simultaneous events:
  - A read and a write to the same register committing on the same edge: the read returns the pre-write value.
  - Registers are written only on a write commit.
- Reset asserted mid-transaction: both FSMs go to idle, held flags clear, registers clear, and any in-flight response is dropped.

## Timing
- Write: AW and W in the same cycle (cycle 0) → s_bvalid high in cycle 1.
  - If one channel arrives at cycle n after the other, s_bvalid rises at n+1.
  - regs_out shows the new value from cycle 1 (commit+1).
- Read: AR handshake in cycle 0 → s_rvalid high in cycle 1.
- Back-to-back throughput: one transaction per 2 cycles per channel when the master's ready/valid signals are held high.
- Handshake rules:
  - No valid output depends combinationally on an input valid.
  - s_bvalid and s_rvalid never drop before their handshake completes.

## Configuration
- AXI_SLV_ERR_RESP_EN defined:
  - Out-of-range write: data discarded, s_bresp=2'b10 (SLVERR).
  - Out-of-range read: s_rdata=0, s_rresp=2'b10.
- AXI_SLV_ERR_RESP_EN undefined:
  - Out-of-range write: data discarded silently, s_bresp=2'b00.
  - Out-of-range read: s_rdata=0, s_rresp=2'b00.
- In-range accesses always return 2'b00 (OKAY).

## Structure
- Shared package axi4lite_pkg holds:
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the write-FSM and read-FSM state encodings.
- One sub-module, axi4lite_reg_bank:
  - the NUM_REGS×32 storage;
  - synchronous write port (enable, index, data) and a registered-read-friendly read port;
  - flat regs_out.
- The top level holds both FSMs, the holding registers and the decode.

## Test plan
- Reset then read addr 0x00 → s_rvalid one cycle after AR, s_rdata=0, s_rresp=OKAY.
- AW 0x08 and W 0xDEADBEEF in the same cycle, s_bready=1 → s_bvalid next cycle, s_bresp=OKAY; regs_out register 2 = 0xDEADBEEF; read 0x08 returns 0xDEADBEEF.
- W 0x12345678 three cycles before AW 0x04 → s_wready low after the W handshake; s_bvalid one cycle after AW; register 1 = 0x12345678.
- s_bready and s_rready held low for 5 cycles → s_bvalid, s_rvalid and s_rdata stable; a second AW or AR is not accepted until the response handshake completes.
- Write 0x3C (index 15 ≥ 12) with AXI_SLV_ERR_RESP_EN defined → s_bresp=SLVERR and registers unchanged. Same write with the macro undefined → OKAY.
- Read and write to 0x0C committing on the same edge (old value 0xA5A5A5A5, new 0x1) → read returns 0xA5A5A5A5. Reset asserted during W_RESP → s_bvalid=0 on the next cycle.
